// File: rtl/kmeans_pkg.sv
// Purpose: shared sizes, state encoding and coordinate indexing for the k-means controller.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package kmeans_pkg;

  localparam int K        = 3;                // centroids
  localparam int D        = 2;                // dimensions
  localparam int NCOORD   = K * D;            // flattened centroid coordinates
  localparam int DATA_W   = 16;               // coordinate width (unsigned)
  localparam int ADDR_W   = 10;               // point memory address width
  localparam int ITER_W   = 8;                // iteration counter width
  localparam int PIPE_LAT = 5;                // pipe_data -> pipe_sel latency
  localparam int CID_W    = 2;                // centroid id width
  localparam int SUM_W    = DATA_W + ADDR_W;  // per-coordinate sum, cannot overflow
  localparam int DIV_CNT_W = $clog2(SUM_W);   // divider step counter

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLEAR,
    S_STREAM,
    S_DRAIN,
    S_DIVIDE,
    S_CHECK,
    S_FINISH
  } state_t;

  // Flattened coordinate index: centroid k, dimension d -> 2*k + d.
  function automatic logic [2:0] coord_idx(input logic [CID_W-1:0] k, input logic d);
    return {k, d};
  endfunction

endpackage

// File: rtl/kmeans_divider.sv
// Purpose: restoring unsigned divider, SUM_W-bit dividend by ADDR_W-bit nonzero divisor.
// Latency: i_start accepted when idle, o_done pulses SUM_W+1 cycles later with o_quotient.
// Backpressure: none; i_start while o_busy is ignored.
// Ports: i_start/i_dividend/i_divisor in; o_busy, o_done (1-cycle pulse), o_quotient (floor, truncated to DATA_W).
module kmeans_divider
  import kmeans_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_start,
  input  logic [SUM_W-1:0]  i_dividend,
  input  logic [ADDR_W-1:0] i_divisor,
  output logic              o_busy,
  output logic              o_done,
  output logic [DATA_W-1:0] o_quotient
);

  logic [ADDR_W-1:0]    r_rem;
  logic [ADDR_W-1:0]    r_dvs;
  logic [SUM_W-1:0]     r_quo;   // dividend shifts out of the top, quotient bits shift in
  logic [DIV_CNT_W-1:0] r_cnt;
  logic                 r_busy;
  logic                 r_done;

  logic [ADDR_W:0] w_rem_shift;
  logic [ADDR_W:0] w_diff;
  logic            w_ge;

  // Remainder is always below the divisor, so one extra bit covers the shifted value.
  assign w_rem_shift = {r_rem, r_quo[SUM_W-1]};
  assign w_ge        = (w_rem_shift >= {1'b0, r_dvs});
  assign w_diff      = w_rem_shift - {1'b0, r_dvs};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rem  <= '0;
      r_dvs  <= '0;
      r_quo  <= '0;
      r_cnt  <= '0;
      r_busy <= 1'b0;
      r_done <= 1'b0;
    end else if (i_start && !r_busy) begin
      r_rem  <= '0;
      r_dvs  <= i_divisor;
      r_quo  <= i_dividend;
      r_cnt  <= DIV_CNT_W'(SUM_W - 1);
      r_busy <= 1'b1;
      r_done <= 1'b0;
    end else if (r_busy) begin
      r_rem <= w_ge ? w_diff[ADDR_W-1:0] : w_rem_shift[ADDR_W-1:0];
      r_quo <= {r_quo[SUM_W-2:0], w_ge};
      if (r_cnt == '0) begin
        r_busy <= 1'b0;
        r_done <= 1'b1;
      end else begin
        r_cnt <= r_cnt - DIV_CNT_W'(1);
      end
    end else begin
      r_done <= 1'b0;
    end
  end

  assign o_busy     = r_busy;
  assign o_done     = r_done;
  assign o_quotient = r_quo[DATA_W-1:0];

endmodule

// File: rtl/kmeans_iter_ctrl.sv
// Purpose: sequences Lloyd k-means (K=3, D=2) around an external distance/argmin pipeline.
// Latency: per iteration ~ 1 + N + PIPE_LAT + 3 + 6*(SUM_W+3) + 1 cycles; done pulses one cycle after the last CHECK.
// Backpressure: none; point memory answers in exactly one cycle, start/init_we ignored while busy.
// Ports: start/num_points/max_iter/init_* control; mem_rd_* point memory; centroid*/pipe_data* to pipeline,
//        pipe_sel from pipeline; busy/done/converged/iter_count status.
module kmeans_iter_ctrl
  import kmeans_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_start,
  input  logic [ADDR_W-1:0] i_num_points,
  input  logic [ITER_W-1:0] i_max_iter,
  input  logic              i_init_we,
  input  logic [CID_W-1:0]  i_init_id,
  input  logic [DATA_W-1:0] i_init_d0,
  input  logic [DATA_W-1:0] i_init_d1,
  output logic              o_mem_rd_en,
  output logic [ADDR_W-1:0] o_mem_rd_addr,
  input  logic [DATA_W-1:0] i_mem_rd_data0,
  input  logic [DATA_W-1:0] i_mem_rd_data1,
  output logic [DATA_W-1:0] o_centroid0_d0,
  output logic [DATA_W-1:0] o_centroid0_d1,
  output logic [DATA_W-1:0] o_centroid1_d0,
  output logic [DATA_W-1:0] o_centroid1_d1,
  output logic [DATA_W-1:0] o_centroid2_d0,
  output logic [DATA_W-1:0] o_centroid2_d1,
  output logic [DATA_W-1:0] o_pipe_data0,
  output logic [DATA_W-1:0] o_pipe_data1,
  input  logic [CID_W-1:0]  i_pipe_sel,
  output logic              o_busy,
  output logic              o_done,
  output logic              o_converged,
  output logic [ITER_W-1:0] o_iter_count
);

  state_t            r_state;
  logic [ADDR_W-1:0] r_num;
  logic [ITER_W-1:0] r_max_iter;
  logic [ITER_W-1:0] r_iter;
  logic              r_busy;
  logic              r_done;
  logic              r_conv;
  logic              r_changed;
  logic              r_rd_en;
  logic [ADDR_W-1:0] r_rd_addr;

  // Point alignment: stage 0 is what the pipeline sees, stage PIPE_LAT lines up with pipe_sel.
  logic              r_rd_vld;
  logic [PIPE_LAT:0] r_vsr;
  logic [DATA_W-1:0] r_dly0 [0:PIPE_LAT];
  logic [DATA_W-1:0] r_dly1 [0:PIPE_LAT];

  logic [DATA_W-1:0] r_cent [0:NCOORD-1];
  logic [DATA_W-1:0] r_new  [0:NCOORD-1];
  logic [SUM_W-1:0]  r_sum  [0:NCOORD-1];
  logic [ADDR_W-1:0] r_cnt  [0:K-1];

  logic [2:0]        r_j;          // coordinate being divided
  logic              r_div_wait;
  logic              r_div_start;

  logic              w_div_busy;
  logic              w_div_done;
  logic [DATA_W-1:0] w_quo;
  logic [CID_W-1:0]  w_k;
  logic              w_cnt_zero;
  logic              w_step;
  logic [DATA_W-1:0] w_step_val;
  logic [2:0]        w_acc_i0;
  logic [2:0]        w_acc_i1;
  logic [2:0]        w_init_i0;
  logic [2:0]        w_init_i1;
  logic [ITER_W-1:0] w_iter_next;

  assign w_k        = r_j[2:1];
  assign w_cnt_zero = (r_cnt[w_k] == '0);
  // Empty cluster steps immediately and keeps the old value; otherwise wait for the quotient.
  assign w_step     = r_div_wait ? w_div_done : w_cnt_zero;
  assign w_step_val = r_div_wait ? w_quo : r_cent[r_j];
  assign w_acc_i0   = coord_idx(i_pipe_sel, 1'b0);
  assign w_acc_i1   = coord_idx(i_pipe_sel, 1'b1);
  assign w_init_i0  = coord_idx(i_init_id, 1'b0);
  assign w_init_i1  = coord_idx(i_init_id, 1'b1);
  assign w_iter_next = r_iter + ITER_W'(1);

  kmeans_divider u_div (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_start    (r_div_start),
    .i_dividend (r_sum[r_j]),
    .i_divisor  (r_cnt[w_k]),
    .o_busy     (w_div_busy),
    .o_done     (w_div_done),
    .o_quotient (w_quo)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rd_vld <= 1'b0;
      r_vsr    <= '0;
      for (int i = 0; i <= PIPE_LAT; i++) begin
        r_dly0[i] <= '0;
        r_dly1[i] <= '0;
      end
    end else begin
      r_rd_vld <= r_rd_en;
      r_vsr    <= {r_vsr[PIPE_LAT-1:0], r_rd_vld};
      if (r_rd_vld) begin
        r_dly0[0] <= i_mem_rd_data0;
        r_dly1[0] <= i_mem_rd_data1;
      end
      for (int i = 1; i <= PIPE_LAT; i++) begin
        r_dly0[i] <= r_dly0[i-1];
        r_dly1[i] <= r_dly1[i-1];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_num       <= '0;
      r_max_iter  <= '0;
      r_iter      <= '0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_conv      <= 1'b0;
      r_changed   <= 1'b0;
      r_rd_en     <= 1'b0;
      r_rd_addr   <= '0;
      r_j         <= '0;
      r_div_wait  <= 1'b0;
      r_div_start <= 1'b0;
      for (int i = 0; i < NCOORD; i++) begin
        r_cent[i] <= '0;
        r_new[i]  <= '0;
        r_sum[i]  <= '0;
      end
      for (int k = 0; k < K; k++) r_cnt[k] <= '0;
    end else begin
      r_done      <= 1'b0;
      r_div_start <= 1'b0;

      // Only fires in STREAM/DRAIN; the shift register is empty everywhere else.
      if (r_vsr[PIPE_LAT] && (i_pipe_sel < CID_W'(K))) begin
        r_sum[w_acc_i0]   <= r_sum[w_acc_i0] + SUM_W'(r_dly0[PIPE_LAT]);
        r_sum[w_acc_i1]   <= r_sum[w_acc_i1] + SUM_W'(r_dly1[PIPE_LAT]);
        r_cnt[i_pipe_sel] <= r_cnt[i_pipe_sel] + ADDR_W'(1);
      end

      case (r_state)
        S_IDLE: begin
          if (i_init_we && (i_init_id < CID_W'(K))) begin
            r_cent[w_init_i0] <= i_init_d0;
            r_cent[w_init_i1] <= i_init_d1;
          end
          if (i_start) begin
            r_num      <= i_num_points;
            r_max_iter <= (i_max_iter == '0) ? ITER_W'(1) : i_max_iter;
            r_iter     <= '0;
            r_busy     <= 1'b1;
            if (i_num_points == '0) begin
              r_conv  <= 1'b1;
              r_state <= S_FINISH;
            end else begin
              r_conv  <= 1'b0;
              r_state <= S_CLEAR;
            end
          end
        end

        S_CLEAR: begin
          for (int i = 0; i < NCOORD; i++) r_sum[i] <= '0;
          for (int k = 0; k < K; k++) r_cnt[k] <= '0;
          r_changed <= 1'b0;
          r_rd_en   <= 1'b1;
          r_rd_addr <= '0;
          r_state   <= S_STREAM;
        end

        S_STREAM: begin
          if (r_rd_addr == r_num - ADDR_W'(1)) begin
            r_rd_en <= 1'b0;
            r_state <= S_DRAIN;
          end else begin
            r_rd_addr <= r_rd_addr + ADDR_W'(1);
          end
        end

        S_DRAIN: begin
          if (!r_rd_vld && (r_vsr == '0)) begin
            r_j        <= '0;
            r_div_wait <= 1'b0;
            r_state    <= S_DIVIDE;
          end
        end

        S_DIVIDE: begin
          if (!r_div_wait && !w_cnt_zero && !w_div_busy) begin
            r_div_start <= 1'b1;
            r_div_wait  <= 1'b1;
          end
          if (w_step) begin
            r_new[r_j] <= w_step_val;
            if (w_step_val != r_cent[r_j]) r_changed <= 1'b1;
            r_div_wait <= 1'b0;
            if (r_j == 3'(NCOORD - 1)) begin
              // Commit all coordinates together; the last one comes straight from this step.
              for (int i = 0; i < NCOORD - 1; i++) r_cent[i] <= r_new[i];
              r_cent[NCOORD-1] <= w_step_val;
              r_state          <= S_CHECK;
            end else begin
              r_j <= r_j + 3'd1;
            end
          end
        end

        S_CHECK: begin
          r_iter <= w_iter_next;
          if (!r_changed) begin
            r_conv  <= 1'b1;
            r_state <= S_FINISH;
          end else if (w_iter_next == r_max_iter) begin
            r_conv  <= 1'b0;
            r_state <= S_FINISH;
          end else begin
            r_state <= S_CLEAR;
          end
        end

        S_FINISH: begin
          r_done  <= 1'b1;
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end

        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign o_mem_rd_en    = r_rd_en;
  assign o_mem_rd_addr  = r_rd_addr;
  assign o_pipe_data0   = r_dly0[0];
  assign o_pipe_data1   = r_dly1[0];
  assign o_centroid0_d0 = r_cent[0];
  assign o_centroid0_d1 = r_cent[1];
  assign o_centroid1_d0 = r_cent[2];
  assign o_centroid1_d1 = r_cent[3];
  assign o_centroid2_d0 = r_cent[4];
  assign o_centroid2_d1 = r_cent[5];
  assign o_busy         = r_busy;
  assign o_done         = r_done;
  assign o_converged    = r_conv;
  assign o_iter_count   = r_iter;

endmodule

// File: tb/tb_kmeans_iter_ctrl.sv
`timescale 1ns/1ps
module tb_kmeans_iter_ctrl;
  import kmeans_pkg::*;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              start;
  logic [ADDR_W-1:0] num_points;
  logic [ITER_W-1:0] max_iter;
  logic              init_we;
  logic [CID_W-1:0]  init_id;
  logic [DATA_W-1:0] init_d0, init_d1;
  logic              mem_rd_en;
  logic [ADDR_W-1:0] mem_rd_addr;
  logic [DATA_W-1:0] rd0, rd1;
  logic [DATA_W-1:0] c00, c01, c10, c11, c20, c21;
  logic [DATA_W-1:0] pd0, pd1;
  logic [CID_W-1:0]  pipe_sel;
  logic              busy, done, conv;
  logic [ITER_W-1:0] iter;

  kmeans_iter_ctrl dut (
    .clk(clk), .rst_n(rst_n), .i_start(start), .i_num_points(num_points), .i_max_iter(max_iter),
    .i_init_we(init_we), .i_init_id(init_id), .i_init_d0(init_d0), .i_init_d1(init_d1),
    .o_mem_rd_en(mem_rd_en), .o_mem_rd_addr(mem_rd_addr), .i_mem_rd_data0(rd0), .i_mem_rd_data1(rd1),
    .o_centroid0_d0(c00), .o_centroid0_d1(c01), .o_centroid1_d0(c10), .o_centroid1_d1(c11),
    .o_centroid2_d0(c20), .o_centroid2_d1(c21), .o_pipe_data0(pd0), .o_pipe_data1(pd1),
    .i_pipe_sel(pipe_sel), .o_busy(busy), .o_done(done), .o_converged(conv), .o_iter_count(iter)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_pass = 0;
  int cyc = 0;
  int start_cyc = 0;
  int done_cnt = 0;
  int model_lat = 5;
  logic             d_conv;
  logic [ITER_W-1:0] d_iter;
  int rd_addr_q[$];
  int rd_cyc_q[$];

  logic [DATA_W-1:0] cw [0:5];
  assign cw[0] = c00; assign cw[1] = c01; assign cw[2] = c10;
  assign cw[3] = c11; assign cw[4] = c20; assign cw[5] = c21;

  // Point memory: one-cycle read latency.
  logic [DATA_W-1:0] mem0 [0:15];
  logic [DATA_W-1:0] mem1 [0:15];
  always @(posedge clk) begin
    if (mem_rd_en) begin
      rd0 <= mem0[mem_rd_addr[3:0]];
      rd1 <= mem1[mem_rd_addr[3:0]];
    end
  end

  // Behavioural distance/argmin pipeline, latency selectable for the alignment probe.
  function automatic logic [1:0] argmin(input logic [DATA_W-1:0] x, input logic [DATA_W-1:0] y);
    longint best, dd, dx, dy;
    logic [1:0] bi;
    best = -1; bi = 2'd0;
    for (int k = 0; k < 3; k++) begin
      dx = longint'(x) - longint'(cw[2*k]);
      dy = longint'(y) - longint'(cw[2*k+1]);
      dd = dx * dx + dy * dy;
      if (best < 0 || dd < best) begin best = dd; bi = 2'(k); end
    end
    return bi;
  endfunction

  logic [1:0] sel_sh [0:7];
  always @(posedge clk) begin
    sel_sh[0] <= argmin(pd0, pd1);
    for (int i = 1; i < 8; i++) sel_sh[i] <= sel_sh[i-1];
  end
  assign pipe_sel = sel_sh[model_lat-1];

  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) begin
    if (done) done_cnt <= done_cnt + 1;
    if (mem_rd_en) begin
      rd_addr_q.push_back(int'(mem_rd_addr));
      rd_cyc_q.push_back(cyc);
    end
  end

  task automatic set_cent(input int id, input int x, input int y);
    @(negedge clk);
    init_we = 1'b1; init_id = CID_W'(id); init_d0 = DATA_W'(x); init_d1 = DATA_W'(y);
    @(negedge clk);
    init_we = 1'b0;
  endtask

  task automatic kick(input int n, input int mi);
    rd_addr_q.delete();
    rd_cyc_q.delete();
    @(negedge clk);
    num_points = ADDR_W'(n); max_iter = ITER_W'(mi); start = 1'b1; start_cyc = cyc;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(output bit got, output int lat);
    got = 1'b0; lat = -1;
    for (int i = 0; i < 5000; i++) begin
      if (done) begin got = 1'b1; lat = cyc - start_cyc; d_conv = conv; d_iter = iter; break; end
      @(negedge clk);
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0; start = 1'b0; init_we = 1'b0; init_id = '0; init_d0 = '0; init_d1 = '0;
    num_points = '0; max_iter = '0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    n_chk++; if (busy !== 1'b0) $display("FAIL reset_busy: got %0d expected 0", busy); else n_pass++;
    n_chk++; if (done !== 1'b0) $display("FAIL reset_done: got %0d expected 0", done); else n_pass++;
    n_chk++; if (mem_rd_en !== 1'b0) $display("FAIL reset_rd_en: got %0d expected 0", mem_rd_en); else n_pass++;
    n_chk++; if (iter !== '0) $display("FAIL reset_iter: got %0d expected 0", iter); else n_pass++;
    n_chk++; if (conv !== 1'b0) $display("FAIL reset_conv: got %0d expected 0", conv); else n_pass++;
    for (int i = 0; i < 6; i++) begin
      n_chk++; if (cw[i] !== '0) $display("FAIL reset_cent[%0d]: got %0d expected 0", i, cw[i]); else n_pass++;
    end
  endtask

  task automatic test_converge;
    bit got; int lat;
    int exp_c[6] = '{1, 0, 101, 100, 201, 0};
    set_cent(0, 0, 0); set_cent(1, 100, 100); set_cent(2, 200, 0);
    kick(6, 10);
    wait_done(got, lat);
    n_chk++; if (!got) $display("FAIL conv_done: got none expected pulse"); else n_pass++;
    n_chk++; if (d_conv !== 1'b1) $display("FAIL conv_flag: got %0d expected 1", d_conv); else n_pass++;
    n_chk++; if (d_iter !== 8'd2) $display("FAIL conv_iter: got %0d expected 2", d_iter); else n_pass++;
    for (int i = 0; i < 6; i++) begin
      n_chk++; if (cw[i] !== exp_c[i][15:0]) $display("FAIL conv_cent[%0d]: got %0d expected %0d", i, cw[i], exp_c[i]); else n_pass++;
    end
  endtask

  task automatic test_iter_limit;
    bit got; int lat;
    int exp_c[6] = '{1, 0, 101, 100, 201, 0};
    set_cent(0, 0, 0); set_cent(1, 100, 100); set_cent(2, 200, 0);
    kick(6, 1);
    wait_done(got, lat);
    n_chk++; if (!got) $display("FAIL lim_done: got none expected pulse"); else n_pass++;
    n_chk++; if (d_conv !== 1'b0) $display("FAIL lim_flag: got %0d expected 0", d_conv); else n_pass++;
    n_chk++; if (d_iter !== 8'd1) $display("FAIL lim_iter: got %0d expected 1", d_iter); else n_pass++;
    for (int i = 0; i < 6; i++) begin
      n_chk++; if (cw[i] !== exp_c[i][15:0]) $display("FAIL lim_cent[%0d]: got %0d expected %0d", i, cw[i], exp_c[i]); else n_pass++;
    end
  endtask

  task automatic test_empty_cluster;
    bit got; int lat;
    int exp_c[6] = '{1, 0, 101, 100, 60000, 60000};
    set_cent(0, 0, 0); set_cent(1, 100, 100); set_cent(2, 60000, 60000);
    kick(4, 3);
    wait_done(got, lat);
    n_chk++; if (!got) $display("FAIL empty_done: got none expected pulse"); else n_pass++;
    n_chk++; if (d_conv !== 1'b1 || d_iter !== 8'd2)
      $display("FAIL empty_status: got conv=%0d iter=%0d expected conv=1 iter=2", d_conv, d_iter); else n_pass++;
    for (int i = 0; i < 6; i++) begin
      n_chk++; if (cw[i] !== exp_c[i][15:0]) $display("FAIL empty_cent[%0d]: got %0d expected %0d", i, cw[i], exp_c[i]); else n_pass++;
    end
  endtask

  task automatic test_zero_points;
    bit got; int lat;
    kick(0, 5);
    wait_done(got, lat);
    repeat (3) @(negedge clk);
    n_chk++; if (!got || lat != 2) $display("FAIL zero_latency: got %0d expected 2", lat); else n_pass++;
    n_chk++; if (d_iter !== '0) $display("FAIL zero_iter: got %0d expected 0", d_iter); else n_pass++;
    n_chk++; if (d_conv !== 1'b1) $display("FAIL zero_conv: got %0d expected 1", d_conv); else n_pass++;
    n_chk++; if (rd_addr_q.size() != 0) $display("FAIL zero_reads: got %0d expected 0", rd_addr_q.size()); else n_pass++;
  endtask

  task automatic test_stream_timing;
    bit got; int lat;
    int exp_c[6] = '{1, 0, 101, 100, 200, 0};
    set_cent(0, 0, 0); set_cent(1, 100, 100); set_cent(2, 200, 0);
    kick(4, 1);
    wait_done(got, lat);
    n_chk++; if (!got || rd_addr_q.size() != 4) $display("FAIL stream_reads: got %0d expected 4", rd_addr_q.size()); else n_pass++;
    if (rd_addr_q.size() == 4) begin
      for (int i = 0; i < 4; i++) begin
        n_chk++; if (rd_addr_q[i] != i || rd_cyc_q[i] != rd_cyc_q[0] + i)
          $display("FAIL stream_addr[%0d]: got addr %0d cyc+%0d expected addr %0d cyc+%0d", i, rd_addr_q[i], rd_cyc_q[i] - rd_cyc_q[0], i, i);
        else n_pass++;
      end
    end
    for (int i = 0; i < 6; i++) begin
      n_chk++; if (cw[i] !== exp_c[i][15:0]) $display("FAIL stream_cent[%0d]: got %0d expected %0d", i, cw[i], exp_c[i]); else n_pass++;
    end
    // A pipeline one cycle slower than the controller's alignment must corrupt the result.
    set_cent(0, 0, 0); set_cent(1, 100, 100); set_cent(2, 200, 0);
    model_lat = PIPE_LAT + 1;
    kick(4, 1);
    wait_done(got, lat);
    model_lat = PIPE_LAT;
    n_chk++; if (!got || (c00 === 16'd1 && c01 === 16'd0))
      $display("FAIL misalign_sensitivity: got c0=(%0d,%0d) expected not (1,0)", c00, c01); else n_pass++;
  endtask

  task automatic test_abort;
    int base; bit seen = 1'b0; int nz = 0;
    set_cent(0, 7, 7); set_cent(1, 100, 100); set_cent(2, 200, 0);
    kick(6, 5);
    for (int i = 0; i < 50 && !seen; i++) begin
      if (mem_rd_en) seen = 1'b1; else @(negedge clk);
    end
    n_chk++; if (!seen) $display("FAIL abort_stream_seen: got no read expected read"); else n_pass++;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    n_chk++; if (busy !== 1'b0) $display("FAIL abort_busy: got %0d expected 0", busy); else n_pass++;
    @(negedge clk);
    rst_n = 1'b1;
    base = done_cnt;
    repeat (60) @(negedge clk);
    n_chk++; if (done_cnt != base) $display("FAIL abort_no_done: got %0d pulses expected 0", done_cnt - base); else n_pass++;
    for (int i = 0; i < 6; i++) if (cw[i] !== '0) nz++;
    n_chk++; if (nz != 0) $display("FAIL abort_cent_zero: got %0d nonzero expected 0", nz); else n_pass++;
    n_chk++; if (busy !== 1'b0 || mem_rd_en !== 1'b0)
      $display("FAIL abort_idle: got busy=%0d rd_en=%0d expected 0 0", busy, mem_rd_en); else n_pass++;
  endtask

  task automatic test_ignored_while_busy;
    bit got; int lat; int base; bit seen = 1'b0;
    int exp_c[6] = '{1, 0, 101, 100, 60000, 60000};
    set_cent(0, 0, 0); set_cent(1, 100, 100); set_cent(2, 60000, 60000);
    base = done_cnt;
    kick(4, 1);
    for (int i = 0; i < 50 && !seen; i++) begin
      if (mem_rd_en) seen = 1'b1; else @(negedge clk);
    end
    init_we = 1'b1; init_id = 2'd2; init_d0 = 16'd5; init_d1 = 16'd5; start = 1'b1; max_iter = 8'd9;
    @(negedge clk);
    init_we = 1'b0; start = 1'b0;
    wait_done(got, lat);
    n_chk++; if (!got || d_iter !== 8'd1 || d_conv !== 1'b0)
      $display("FAIL busy_status: got done=%0d iter=%0d conv=%0d expected 1 1 0", got, d_iter, d_conv); else n_pass++;
    for (int i = 0; i < 6; i++) begin
      n_chk++; if (cw[i] !== exp_c[i][15:0]) $display("FAIL busy_cent[%0d]: got %0d expected %0d", i, cw[i], exp_c[i]); else n_pass++;
    end
    repeat (20) @(negedge clk);
    n_chk++; if (busy !== 1'b0 || done_cnt != base + 1)
      $display("FAIL busy_no_rerun: got busy=%0d pulses=%0d expected 0 1", busy, done_cnt - base); else n_pass++;
  endtask

  initial begin
    for (int i = 0; i < 16; i++) begin mem0[i] = '0; mem1[i] = '0; end
    mem0[0] = 16'd0;   mem1[0] = 16'd0;
    mem0[1] = 16'd2;   mem1[1] = 16'd0;
    mem0[2] = 16'd100; mem1[2] = 16'd100;
    mem0[3] = 16'd102; mem1[3] = 16'd100;
    mem0[4] = 16'd200; mem1[4] = 16'd0;
    mem0[5] = 16'd202; mem1[5] = 16'd0;
    test_reset();
    test_converge();
    test_iter_limit();
    test_empty_cluster();
    test_zero_points();
    test_stream_timing();
    test_abort();
    test_ignored_while_busy();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/kmeans_iter_ctrl.md
Name: kmeans_iter_ctrl

Overview:
- Sequences one full Lloyd k-means run (K=3, D=2) around the k3_d2 distance/argmin pipeline.
- Holds the centroid registers and drives them into the pipeline.
- Streams points from an external point memory, aligns the returned labels with a valid shift register, and accumulates per-centroid sums and counts.
- Recomputes centroids with one shared iterative divider, repeating until converged or until max_iter is reached.

Parameters:
- DATA_W, 16, point/centroid coordinate width (unsigned)
- ADDR_W, 10, point memory address width; max points 2^ADDR_W-1
- ITER_W, 8, iteration counter width
- PIPE_LAT, 5, distance-pipeline latency from point input to selected_centroid
- CID_W, 2, centroid id width

Ports:
- clk  in  1  clock
- rst_n  in  1  async active-low reset
- start  in  1  one-cycle pulse; begin run (ignored unless IDLE)
- num_points  in  ADDR_W  points in memory at addresses 0..num_points-1, sampled at start
- max_iter  in  ITER_W  iteration limit, sampled at start; 0 treated as 1
- init_we  in  1  write initial centroid (honoured only in IDLE)
- init_id  in  CID_W  centroid index 0..2; 3 ignored
- init_d0 / init_d1  in  DATA_W  initial coordinates
- mem_rd_en  out  1  point memory read strobe
- mem_rd_addr  out  ADDR_W  read address
- mem_rd_data0 / mem_rd_data1  in  DATA_W  point data, valid exactly 1 cycle after mem_rd_en
- centroid{0,1,2}_d{0,1}  out  DATA_W  current centroids to pipeline (registered)
- pipe_data0 / pipe_data1  out  DATA_W  point to pipeline
- pipe_sel  in  CID_W  selected_centroid from pipeline
- busy  out  1  high in any state except IDLE
- done  out  1  one-cycle pulse at end of run
- converged  out  1  valid with done; 1 if last iteration changed no centroid
- iter_count  out  ITER_W  iterations completed, held after done until next start

Behaviour:
- Reset: state IDLE; all centroid registers 0; busy, done, converged, mem_rd_en, iter_count, accumulators, counts, and valid shift register all 0. Reset mid-run aborts immediately and does not emit done.
- IDLE: init_we writes centroid[init_id]. On start: latch num_points and max_iter, clear iter_count, go to CLEAR. If num_points==0, skip to FINISH with converged=1 and iter_count=0.
- CLEAR (1 cycle): zero sum[k][d] (width DATA_W+ADDR_W) and cnt[k] (ADDR_W); clear the changed flag.
- STREAM: issue mem_rd_en with addr 0..num_points-1, one per cycle, no bubbles. Data returned the next cycle is registered onto pipe_data0/1 and a valid bit is pushed into a valid shift register together with a point-data delay line. The total delay from pipe_data to pipe_sel is PIPE_LAT cycles. After the last address is issued, go to DRAIN.
- DRAIN: wait until the valid shift register is empty (PIPE_LAT+1 cycles after the last read).
- Accumulate (in STREAM and DRAIN): when the delayed valid bit is 1, do sum[pipe_sel][d] += delayed point[d] and cnt[pipe_sel] += 1. pipe_sel==3 is ignored. Sums do not overflow by construction of the width.
- Centroids stay frozen during STREAM/DRAIN.
- DIVIDE: for j=0..5 (k=j/2, d=j%2), start kmeans_divider(sum[k][d], cnt[k]); wait for its done. The quotient is truncated (floor). If cnt[k]==0, skip the divider and keep the old centroid. A quotient different from the old value sets the changed flag. All six new values are committed to the centroid registers together when DIVIDE exits.
- CHECK: increment iter_count.
  - If changed==0: go to FINISH with converged=1.
  - Else if iter_count==max_iter: go to FINISH with converged=0.
  - Else: go to CLEAR.
- FINISH: pulse done for 1 cycle, go to IDLE.
- start while busy: ignored. init_we while busy: ignored.

Decomposition:
- Shared package kmeans_pkg holds K=3, D=2, the state encoding enum, and the widths DATA_W, CID_W, SUM_W=DATA_W+ADDR_W.
- One sub-module, kmeans_divider: restoring unsigned divider, SUM_W-bit dividend, ADDR_W-bit divisor, SUM_W cycles. Ports: start/busy/done, quotient truncated to DATA_W. The divisor is guaranteed nonzero by the caller.

Test Plan:
- Two-iteration convergence:
  - Stimulus: init centroids (0,0),(100,100),(200,0); points (0,0),(2,0),(100,100),(102,100),(200,0),(202,0), with a behavioural pipeline model at PIPE_LAT=5.
  - Iteration 1 yields centroids (1,0),(101,100),(201,0).
  - Iteration 2 changes nothing, so done pulses with converged=1 and iter_count=2.
- Iteration limit:
  - Stimulus: same data as the convergence test, max_iter=1.
  - Response: done after 1 iteration, converged=0, iter_count=1, centroids (1,0),(101,100),(201,0).
- Empty cluster:
  - Stimulus: centroid2=(60000,60000); all points near the other centroids.
  - Response: cnt[2]=0 and centroid2 stays (60000,60000).
- num_points=0:
  - Stimulus: start with num_points=0.
  - Response: no mem_rd_en; done 2 cycles after start; iter_count=0; converged=1.
- Stream timing:
  - Stimulus: N=4.
  - Response: mem_rd_en high for exactly 4 consecutive cycles with addr 0..3. Accumulation uses pipe_sel exactly PIPE_LAT cycles after each pipe_data. A mis-aligned model (PIPE_LAT+1) must produce the wrong result, which confirms the bench's alignment check is sensitive.
- Abort and ignored inputs:
  - Stimulus: assert rst_n=0 mid-STREAM; separately, pulse start and init_we while busy.
  - Response: after the reset, busy=0, centroids=0, and no done. The start and init_we pulses while busy have no effect.
